// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one async_transmitter (RegisterInputData=1).
// Optional stall timeout inside a message is enabled with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TIMEOUT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 timeout_err
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDrain} stateT;

    stateT              state;
    logic [NUM_REQ-1:0] grantQ;
    logic [IdxW-1:0]    ownerQ;
    logic [IdxW-1:0]    ptrQ;
    logic               lastQ;

    logic [IdxW-1:0]    pickIdx;
    logic               pickValid;
    logic [IdxW-1:0]    nextPtr;
    int                 cand;
    logic               ownerValid;
    logic               ownerLast;
    logic [7:0]         ownerData;
    logic               fire;

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        cand      = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = int'(ptrQ) + k;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            if (req_valid[IdxW'(cand)]) begin
                pickValid = 1'b1;
                pickIdx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        ownerData = 8'h00;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grantQ[i]) begin
                ownerData = req_data[8*i +: 8];
            end
        end
    end

    assign ownerValid = |(req_valid & grantQ);
    assign ownerLast  = |(req_last & grantQ);
    assign nextPtr    = (int'(ownerQ) == int'(NUM_REQ) - 1) ? '0 : ownerQ + 1'b1;

    assign fire      = (state == StSend) && ownerValid && !tx_busy;
    assign tx_start  = fire;
    assign req_ready = fire ? grantQ : '0;
    assign tx_data   = (state == StSend) ? ownerData : 8'h00;
    assign grant     = grantQ;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] toCnt;
    logic                 timeoutErrQ;

    assign timeout_err = timeoutErrQ;
`else
    logic unusedTimeout;

    assign timeout_err   = 1'b0;
    assign unusedTimeout = ^{TIMEOUT_CYCLES, TIMEOUT_W};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= StIdle;
            grantQ <= '0;
            ownerQ <= '0;
            ptrQ   <= '0;
            lastQ  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            toCnt       <= '0;
            timeoutErrQ <= 1'b0;
`endif
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeoutErrQ <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (pickValid) begin
                        grantQ <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
                        ownerQ <= pickIdx;
                        state  <= StSend;
                    end
                end
                StSend: begin
                    if (fire) begin
                        lastQ <= ownerLast;
                        state <= StGap;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        toCnt <= '0;
`endif
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (!ownerValid) begin
                        if (toCnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                            timeoutErrQ <= 1'b1;
                            grantQ      <= '0;
                            ptrQ        <= nextPtr;
                            toCnt       <= '0;
                            state       <= StIdle;
                        end else begin
                            toCnt <= toCnt + 1'b1;
                        end
                    end
`endif
                end
                // Transmitter raises busy one cycle after start, so busy is ignored here.
                StGap: begin
                    state <= StDrain;
                end
                StDrain: begin
                    if (!tx_busy) begin
                        if (lastQ) begin
                            grantQ <= '0;
                            ptrQ   <= nextPtr;
                            state  <= StIdle;
                        end else begin
                            state <= StSend;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration vector table plus hand-written corner cases.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [3:0]  grant;
    logic        timeout_err;
    logic        busyForce;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .TIMEOUT_CYCLES(10),
        .TIMEOUT_W     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for 5 cycles starting the cycle after a start pulse.
    int busyCnt = 0;
    always @(posedge clk) begin
        if (tx_start) busyCnt <= 5;
        else if (busyCnt != 0) busyCnt <= busyCnt - 1;
    end
    assign tx_busy = (busyCnt != 0) || busyForce;

    typedef struct {
        logic [3:0]  mask;
        int          nOwn;
        logic [15:0] order;
    } vecT;

    vecT         vecs[7];
    logic [7:0]  mData[4][16];
    logic        mLast[4][16];
    int          mCnt[4];
    int          mPos[4];
    logic [7:0]  logData[$];
    logic [3:0]  logGrant[$];
    int          logCyc[$];
    logic [3:0]  xfer;
    int          cyc = 0;
    int          nTests = 0;
    int          nFail = 0;
    int          startWhileBusy = 0;
    int          readyNonOwner = 0;
    int          dataWhenIdle = 0;
    int          errSeen = 0;
    int          lastGrantCyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (mPos[i] < mCnt[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = mData[i][mPos[i]];
                req_last[i]        = mLast[i][mPos[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic addByte(input int i, input logic [7:0] d, input logic l);
        if (mPos[i] == mCnt[i]) begin
            mPos[i] = 0;
            mCnt[i] = 0;
        end
        mData[i][mCnt[i]] = d;
        mLast[i][mCnt[i]] = l;
        mCnt[i]++;
    endtask

    function automatic bit allDrained();
        for (int i = 0; i < 4; i++) if (mPos[i] != mCnt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clearLog();
        logData.delete();
        logGrant.delete();
        logCyc.delete();
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        xfer = req_valid & req_ready;
        if (tx_start) begin
            logData.push_back(tx_data);
            logGrant.push_back(grant);
            logCyc.push_back(cyc);
            if (tx_busy) startWhileBusy++;
        end
        if ((req_ready & ~grant) != 4'b0) readyNonOwner++;
        if (grant == 4'b0 && tx_data != 8'h00) dataWhenIdle++;
        if (timeout_err) errSeen++;
        if (grant != 4'b0) lastGrantCyc = cyc;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) if (xfer[i]) mPos[i]++;
        drive();
    endtask

    task automatic runUntilIdle(input string name, input int maxCyc);
        bit done;
        done = 1'b0;
        for (int n = 0; n < maxCyc && !done; n++) begin
            sampleCycle();
            advance();
            if (allDrained() && grant == 4'b0) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   found;
        int   owner;
        int   idx;
        int   badGap;
        int   r0ready;

        vecs[0] = '{4'b0101, 2, 16'h0020};
        vecs[1] = '{4'b1010, 2, 16'h0013};
        vecs[2] = '{4'b1010, 2, 16'h0013};
        vecs[3] = '{4'b1111, 4, 16'h1032};
        vecs[4] = '{4'b0001, 1, 16'h0000};
        vecs[5] = '{4'b0011, 2, 16'h0001};
        vecs[6] = '{4'b1000, 1, 16'h0003};

        reset     = 1'b1;
        busyForce = 1'b0;
        xfer      = 4'b0;
        for (int i = 0; i < 4; i++) begin
            mCnt[i] = 0;
            mPos[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        sampleCycle();
        check("reset outputs", 32'({grant, req_ready, tx_start, tx_data, timeout_err}), 32'd0);
        advance();

        // Three-byte message from req0.
        clearLog();
        addByte(0, 8'h11, 1'b0);
        addByte(0, 8'h22, 1'b0);
        addByte(0, 8'h33, 1'b1);
        drive();
        sampleCycle();
        check("t1 idle cycle", 32'({grant, tx_start}), 32'd0);
        advance();
        sampleCycle();
        check("t1 first start", 32'({grant, req_ready, tx_start, tx_data}),
              32'({4'b0001, 4'b0001, 1'b1, 8'h11}));
        advance();
        runUntilIdle("t1 idle reached", 200);
        check("t1 byte count", 32'(logData.size()), 32'd3);
        if (logData.size() == 3) begin
            check("t1 data order", 32'({logData[0], logData[1], logData[2]}), 32'h112233);
            check("t1 grant", 32'({logGrant[0], logGrant[1], logGrant[2]}), 32'h111);
            check("t1 byte spacing", 32'({logCyc[1] - logCyc[0], logCyc[2] - logCyc[1]}),
                  32'({32'd7, 32'd7}));
            check("t1 release", 32'(lastGrantCyc - logCyc[2]), 32'd6);
        end

        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        // Arbitration table: two-byte messages, pointer carries across records.
        for (int r = 0; r < 7; r++) begin
            clearLog();
            for (int i = 0; i < 4; i++) begin
                if (vecs[r].mask[i]) begin
                    addByte(i, 8'(r * 16 + i * 4), 1'b0);
                    addByte(i, 8'(r * 16 + i * 4 + 1), 1'b1);
                end
            end
            drive();
            runUntilIdle($sformatf("vec%0d idle", r), 400);
            check($sformatf("vec%0d count", r), 32'(logData.size()), 32'(2 * vecs[r].nOwn));
            badGap = 0;
            for (int k = 0; k < vecs[r].nOwn; k++) begin
                owner = int'(vecs[r].order[4*k +: 4]);
                for (int b = 0; b < 2; b++) begin
                    idx = 2 * k + b;
                    if (idx < logData.size()) begin
                        check($sformatf("vec%0d byte%0d", r, idx),
                              32'({logGrant[idx], logData[idx]}),
                              32'({4'(1 << owner), 8'(r * 16 + owner * 4 + b)}));
                        if (idx > 0 && logCyc[idx] - logCyc[idx-1] != ((b == 1) ? 7 : 8))
                            badGap++;
                    end
                end
            end
            check($sformatf("vec%0d spacing", r), 32'(badGap), 32'd0);
        end

        // Busy already high when SEND is entered.
        clearLog();
        busyForce = 1'b1;
        addByte(1, 8'h44, 1'b1);
        drive();
        sampleCycle();
        advance();
        sampleCycle();
        check("t4 granted", 32'(grant), 32'b0010);
        check("t4 no start", 32'({tx_start, req_ready}), 32'd0);
        advance();
        repeat (3) begin
            sampleCycle();
            advance();
        end
        check("t4 held off", 32'(logData.size()), 32'd0);
        busyForce = 1'b0;
        sampleCycle();
        check("t4 start", 32'({tx_start, tx_data}), 32'({1'b1, 8'h44}));
        advance();
        runUntilIdle("t4 idle", 100);

        // Reset while draining; pointer must return to 0.
        clearLog();
        addByte(2, 8'h55, 1'b0);
        addByte(2, 8'h56, 1'b1);
        drive();
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            sampleCycle();
            if (tx_start) found = 1'b1;
            advance();
        end
        check("t5 first start", 32'(found), 32'd1);
        sampleCycle();
        advance();
        sampleCycle();
        check("t5 grant in drain", 32'(grant), 32'b0100);
        reset = 1'b1;
        #1;
        check("t5 reset clears", 32'({grant, req_ready, tx_start}), 32'd0);
        clearLog();
        addByte(1, 8'h66, 1'b1);
        advance();
        reset = 1'b0;
        sampleCycle();
        check("t5 idle after reset", 32'(grant), 32'd0);
        advance();
        sampleCycle();
        check("t5 pointer reset", 32'(grant), 32'b0010);
        check("t5 waits busy", 32'(tx_start), 32'd0);
        advance();
        runUntilIdle("t5 idle", 200);
        check("t5 byte count", 32'(logData.size()), 32'd2);
        if (logData.size() == 2)
            check("t5 order", 32'({logGrant[0], logData[0], logGrant[1], logData[1]}),
                  32'({4'b0010, 8'h66, 4'b0100, 8'h56}));

        // Owner req3 stalls mid-message while req0 waits.
        clearLog();
        addByte(3, 8'h77, 1'b0);
        addByte(0, 8'h88, 1'b1);
        drive();
`ifdef UART_TX_ARB_TIMEOUT_EN
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            sampleCycle();
            if (timeout_err) begin
                found = 1'b1;
                check("t6 grant cleared", 32'(grant), 32'd0);
                if (logCyc.size() > 0)
                    check("t6 timeout delay", 32'(cyc - logCyc[0]), 32'd17);
            end
            advance();
        end
        check("t6 timeout seen", 32'(found), 32'd1);
        check("t6 single pulse", 32'(errSeen), 32'd1);
`else
        r0ready = 0;
        for (int n = 0; n < 1000; n++) begin
            sampleCycle();
            if (req_ready[0]) r0ready++;
            advance();
        end
        check("t6 grant held", 32'(grant), 32'b1000);
        check("t6 one byte sent", 32'(logData.size()), 32'd1);
        check("t6 req0 ignored", 32'(r0ready), 32'd0);
        check("t6 no timeout", 32'(errSeen), 32'd0);
`endif

        check("start while busy", 32'(startWhileBusy), 32'd0);
        check("ready to non-owner", 32'(readyNonOwner), 32'd0);
        check("data while idle", 32'(dataWhenIdle), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
